// File: rtl/mc_pkg.sv
// Shared state, opcode, ALU and mux-select encodings for the multi-cycle MIPS control FSM.
// Build option: define MC_JAL_EN to add the JAL state for opcode 0x03.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
`ifdef MC_JAL_EN
        , S_JAL     = 4'd12
`endif
    } state_t;

    // Which ALU operation family the state being entered needs.
    typedef enum logic [1:0] {
        ALU_CLS_ADD   = 2'd0,
        ALU_CLS_SUB   = 2'd1,
        ALU_CLS_RTYPE = 2'd2,
        ALU_CLS_ITYPE = 2'd3
    } alu_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic       IORD_PC     = 1'b0;
    localparam logic       IORD_ALUOUT = 1'b1;
    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_RA   = 2'b10;
    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;
    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_A      = 1'b1;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BROFF  = 2'b11;
    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       branch;
        logic       branch_ne;
    } ctrl_t;

    // Opcode-independent control word of a state; alu_ctrl, zero_ext and branch_ne are filled in by the caller.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.i_or_d    = IORD_PC;
                c.ir_write  = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_source = PCSRC_ALU;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_BROFF;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = IORD_ALUOUT;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RT;
                c.mem_to_reg = M2R_MDR;
                c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = IORD_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_B;
            end
            S_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RD;
                c.mem_to_reg = M2R_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_I_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RT;
                c.mem_to_reg = M2R_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_A;
                c.alu_src_b  = SRCB_B;
                c.pc_source  = PCSRC_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_source  = PCSRC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RA;
                c.mem_to_reg = M2R_PC;
                c.pc_source  = PCSRC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_control_decode.sv
// ALU operation decode for the multi-cycle control FSM: maps the ALU class of the
// state being entered plus opcode/funct onto an alu_ctrl code, and flags legal R-type functs.
module alu_control_decode
    import mc_pkg::*;
(
    input  alu_cls_t   cls_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       funct_legal_o
);

    assign funct_legal_o = (funct_i == FN_ADD) || (funct_i == FN_SUB) || (funct_i == FN_AND) ||
                           (funct_i == FN_OR)  || (funct_i == FN_SLT);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (cls_i)
            ALU_CLS_ADD: alu_ctrl_o = ALU_ADD;
            ALU_CLS_SUB: alu_ctrl_o = ALU_SUB;
            ALU_CLS_RTYPE: begin
                case (funct_i)
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            ALU_CLS_ITYPE: begin
                case (opcode_i)
                    OP_ANDI: alu_ctrl_o = ALU_AND;
                    OP_ORI:  alu_ctrl_o = ALU_OR;
                    OP_SLTI: alu_ctrl_o = ALU_SLT;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Build option: MC_JAL_EN enables the JAL state; otherwise opcode 0x03 decodes as illegal.
module multi_cycle_control
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             zero_ext,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] count_q;
    alu_cls_t         alu_cls;
    logic [3:0]       alu_ctrl_next;
    logic             funct_legal;
    logic             illegal_d;

    // ALU class is chosen from the current state so the decoder never depends on state_d.
    always_comb begin
        alu_cls = ALU_CLS_ADD;
        if (state_q == S_DECODE) begin
            case (opcode)
                OP_RTYPE:                         alu_cls = ALU_CLS_RTYPE;
                OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: alu_cls = ALU_CLS_ITYPE;
                OP_BEQ, OP_BNE:                   alu_cls = ALU_CLS_SUB;
                default:                          alu_cls = ALU_CLS_ADD;
            endcase
        end
    end

    alu_control_decode u_alu_dec (
        .cls_i         (alu_cls),
        .opcode_i      (opcode),
        .funct_i       (funct),
        .alu_ctrl_o    (alu_ctrl_next),
        .funct_legal_o (funct_legal)
    );

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
`ifdef MC_JAL_EN
                    OP_JAL:                            state_d = S_JAL;
`endif
                    OP_RTYPE: begin
                        if (funct_legal) begin
                            state_d = S_R_EXEC;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_d = S_MEM_WB;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl_d           = state_ctrl(state_d);
        ctrl_d.alu_ctrl  = alu_ctrl_next;
        ctrl_d.zero_ext  = (state_d == S_I_EXEC) && ((opcode == OP_ANDI) || (opcode == OP_ORI));
        ctrl_d.branch_ne = ctrl_d.branch && (opcode == OP_BNE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (ctrl_q.instr_done) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // ctrl_q already holds the FETCH word during reset so the first edge after release fetches;
    // the reset mask keeps every output quiet until then.
    assign pc_write    = ~reset & (ctrl_q.pc_write | (ctrl_q.branch & (zero ^ ctrl_q.branch_ne)));
    assign i_or_d      = ~reset & ctrl_q.i_or_d;
    assign mem_read    = ~reset & ctrl_q.mem_read;
    assign mem_write   = ~reset & ctrl_q.mem_write;
    assign ir_write    = ~reset & ctrl_q.ir_write;
    assign reg_dst     = reset ? '0 : ctrl_q.reg_dst;
    assign mem_to_reg  = reset ? '0 : ctrl_q.mem_to_reg;
    assign reg_write   = ~reset & ctrl_q.reg_write;
    assign alu_src_a   = ~reset & ctrl_q.alu_src_a;
    assign alu_src_b   = reset ? '0 : ctrl_q.alu_src_b;
    assign zero_ext    = ~reset & ctrl_q.zero_ext;
    assign alu_ctrl    = reset ? '0 : ctrl_q.alu_ctrl;
    assign pc_source   = reset ? '0 : ctrl_q.pc_source;
    assign instr_done  = ~reset & ctrl_q.instr_done;
    assign illegal_op  = ~reset & illegal_d;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
`timescale 1ns/1ps
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_multi_cycle_control;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic        alu_src_a, zero_ext, instr_done, illegal_op;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [3:0]  alu_ctrl, state;
    logic [31:0] instr_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_count;
    state_t      seq[$];
    bit          legal;
    logic [5:0]  ops[12];
    logic [5:0]  fns[5];

    multi_cycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext), .alu_ctrl(alu_ctrl),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if ((mem_read & mem_write) !== 1'b0) begin
                failures++;
                $error("FAIL monitor: mem_read and mem_write both high in state %0d", state);
            end
            checks++;
            if ((illegal_op === 1'b1) && (state !== S_DECODE)) begin
                failures++;
                $error("FAIL monitor: illegal_op outside DECODE, state %0d", state);
            end
            checks++;
            if ((ir_write === 1'b1) && (state !== S_FETCH)) begin
                failures++;
                $error("FAIL monitor: ir_write outside FETCH, state %0d", state);
            end
            checks++;
            if ((instr_done & illegal_op) !== 1'b0) begin
                failures++;
                $error("FAIL monitor: instr_done and illegal_op both high in state %0d", state);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23, 6'h2B, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D: return 1'b1;
            6'h00: return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
`ifdef MC_JAL_EN
            6'h03: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
        legal = is_legal(op, fn);
        seq   = '{S_FETCH, S_DECODE};
        if (legal) begin
            case (op)
                6'h23: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_READ); seq.push_back(S_MEM_WB); end
                6'h2B: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_WRITE); end
                6'h00: begin seq.push_back(S_R_EXEC); seq.push_back(S_R_WB); end
                6'h04, 6'h05: seq.push_back(S_BRANCH);
                6'h02: seq.push_back(S_JUMP);
`ifdef MC_JAL_EN
                6'h03: seq.push_back(S_JAL);
`endif
                default: begin seq.push_back(S_I_EXEC); seq.push_back(S_I_WB); end
            endcase
        end
    endtask

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'h0C:   return 4'b0000;
            6'h0D:   return 4'b0001;
            6'h0A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic check_cycle(input int k, input logic [5:0] op, input logic [5:0] fn, input logic z);
        state_t s;
        string  n;
        bit     last;
        s    = seq[k];
        n    = s.name();
        last = (k == seq.size() - 1);
        `CHK($sformatf("state[%0d]", k), state, s);
        `CHK({n, ".mem_read"},   mem_read,   (s == S_FETCH) || (s == S_MEM_READ));
        `CHK({n, ".ir_write"},   ir_write,   s == S_FETCH);
        `CHK({n, ".mem_write"},  mem_write,  s == S_MEM_WRITE);
`ifdef MC_JAL_EN
        `CHK({n, ".reg_write"},  reg_write,  (s == S_MEM_WB) || (s == S_R_WB) || (s == S_I_WB) || (s == S_JAL));
        `CHK({n, ".pc_write"},   pc_write,   (s == S_FETCH) || (s == S_JUMP) || (s == S_JAL) ||
                                             ((s == S_BRANCH) && ((op == 6'h05) ? !z : z)));
`else
        `CHK({n, ".reg_write"},  reg_write,  (s == S_MEM_WB) || (s == S_R_WB) || (s == S_I_WB));
        `CHK({n, ".pc_write"},   pc_write,   (s == S_FETCH) || (s == S_JUMP) ||
                                             ((s == S_BRANCH) && ((op == 6'h05) ? !z : z)));
`endif
        `CHK({n, ".instr_done"}, instr_done, last && legal);
        `CHK({n, ".illegal_op"}, illegal_op, (s == S_DECODE) && !legal);
        case (s)
            S_FETCH: begin
                `CHK("FETCH.i_or_d", i_or_d, 1'b0);
                `CHK("FETCH.srcA", alu_src_a, 1'b0);
                `CHK("FETCH.srcB", alu_src_b, 2'b01);
                `CHK("FETCH.alu", alu_ctrl, 4'b0010);
                `CHK("FETCH.pcsrc", pc_source, 2'b00);
            end
            S_DECODE: begin
                `CHK("DECODE.srcA", alu_src_a, 1'b0);
                `CHK("DECODE.srcB", alu_src_b, 2'b11);
                `CHK("DECODE.alu", alu_ctrl, 4'b0010);
            end
            S_MEM_ADDR: begin
                `CHK("MEM_ADDR.srcA", alu_src_a, 1'b1);
                `CHK("MEM_ADDR.srcB", alu_src_b, 2'b10);
                `CHK("MEM_ADDR.alu", alu_ctrl, 4'b0010);
            end
            S_MEM_READ, S_MEM_WRITE: `CHK({n, ".i_or_d"}, i_or_d, 1'b1);
            S_MEM_WB, S_I_WB: begin
                `CHK({n, ".reg_dst"}, reg_dst, 2'b00);
                `CHK({n, ".mem_to_reg"}, mem_to_reg, (s == S_MEM_WB) ? 2'b01 : 2'b00);
            end
            S_R_EXEC: begin
                `CHK("R_EXEC.srcA", alu_src_a, 1'b1);
                `CHK("R_EXEC.srcB", alu_src_b, 2'b00);
                `CHK("R_EXEC.alu", alu_ctrl, r_alu(fn));
            end
            S_R_WB: begin
                `CHK("R_WB.reg_dst", reg_dst, 2'b01);
                `CHK("R_WB.mem_to_reg", mem_to_reg, 2'b00);
            end
            S_I_EXEC: begin
                `CHK("I_EXEC.srcA", alu_src_a, 1'b1);
                `CHK("I_EXEC.srcB", alu_src_b, 2'b10);
                `CHK("I_EXEC.alu", alu_ctrl, i_alu(op));
                `CHK("I_EXEC.zero_ext", zero_ext, (op == 6'h0C) || (op == 6'h0D));
            end
            S_BRANCH: begin
                `CHK("BRANCH.srcA", alu_src_a, 1'b1);
                `CHK("BRANCH.srcB", alu_src_b, 2'b00);
                `CHK("BRANCH.alu", alu_ctrl, 4'b0110);
                `CHK("BRANCH.pcsrc", pc_source, 2'b01);
            end
            S_JUMP: `CHK("JUMP.pcsrc", pc_source, 2'b10);
`ifdef MC_JAL_EN
            S_JAL: begin
                `CHK("JAL.reg_dst", reg_dst, 2'b10);
                `CHK("JAL.mem_to_reg", mem_to_reg, 2'b10);
                `CHK("JAL.pcsrc", pc_source, 2'b10);
            end
`endif
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
        build_seq(op, fn);
        for (int k = 0; k < seq.size(); k++) begin
            @(negedge clk);
            check_cycle(k, op, fn, z);
            @(posedge clk);
            #1;
        end
        if (legal) exp_count = exp_count + 1;
        `CHK($sformatf("instr_count op=%0h fn=%0h", op, fn), instr_count, exp_count);
    endtask

    task automatic check_quiet(input string tag);
        `CHK({tag, ".state"}, state, S_FETCH);
        `CHK({tag, ".enables"}, {pc_write, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op}, 7'b0);
        `CHK({tag, ".selects"}, {i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_ctrl, pc_source}, 16'b0);
    endtask

    initial begin
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h03, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        reset     = 1'b1;
        opcode    = 6'h23;
        funct     = 6'h00;
        zero      = 1'b0;
        exp_count = 0;

        repeat (3) begin
            @(negedge clk);
            check_quiet("reset");
            `CHK("reset.instr_count", instr_count, 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(6'h23, 6'h00, 1'b0);
        run_instr(6'h00, 6'h2A, 1'b0);
        run_instr(6'h00, 6'h20, 1'b1);
        run_instr(6'h00, 6'h22, 1'b0);
        run_instr(6'h00, 6'h24, 1'b0);
        run_instr(6'h00, 6'h25, 1'b0);
        run_instr(6'h08, 6'h11, 1'b0);
        run_instr(6'h0C, 6'h00, 1'b0);
        run_instr(6'h0D, 6'h3F, 1'b1);
        run_instr(6'h0A, 6'h00, 1'b0);
        run_instr(6'h04, 6'h00, 1'b1);
        run_instr(6'h04, 6'h00, 1'b0);
        run_instr(6'h05, 6'h00, 1'b1);
        run_instr(6'h05, 6'h00, 1'b0);
        run_instr(6'h02, 6'h00, 1'b0);
        run_instr(6'h03, 6'h00, 1'b0);
        run_instr(6'h2B, 6'h00, 1'b0);
        run_instr(6'h3F, 6'h00, 1'b0);
        run_instr(6'h00, 6'h00, 1'b0);

        opcode = 6'h2B;
        funct  = 6'h00;
        zero   = 1'b0;
        repeat (4) @(negedge clk);
        `CHK("sw.state_before_reset", state, S_MEM_WRITE);
        `CHK("sw.mem_write_before_reset", mem_write, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_quiet("async_reset");
        exp_count = 0;
        `CHK("async_reset.instr_count", instr_count, exp_count);
        @(posedge clk);
        #1;
        check_quiet("reset_held");
        reset = 1'b0;
        run_instr(6'h23, 6'h00, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op, fn;
            logic       z;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
            z  = 1'($urandom_range(0, 1));
            run_instr(op, fn, z);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Main control FSM for the multi-cycle MIPS datapath that replaces the single-cycle core. It decodes the instruction latched in IR, steps it through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over 3–5 clocks, and drives every mux select and write enable of the shared-memory, single-ALU datapath. It sits beside the datapath inside the multi-cycle top and is the only source of its control signals.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces FSM to FETCH
- opcode  input  6  IR[31:26]; stable from the cycle after FETCH
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, same cycle
- pc_write  output  1  PC load enable; already resolved for beq/bne
- i_or_d  output  1  0 = memory address from PC, 1 = from ALUOut
- mem_read / mem_write  output  1 each  memory strobes
- ir_write  output  1  IR load enable
- reg_dst  output  2  00 rt, 01 rd, 10 $31
- mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  output  1  register-file write enable
- alu_src_a  output  1  0 PC, 1 A
- alu_src_b  output  2  00 B, 01 const 4, 10 ext imm, 11 sext imm<<2
- zero_ext  output  1  1 = zero-extend imm (andi/ori)
- alu_ctrl  output  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- pc_source  output  2  00 ALU, 01 ALUOut, 10 jump target
- instr_done  output  1  one-cycle pulse in each instruction's final state
- illegal_op  output  1  one-cycle pulse in DECODE on unsupported opcode/funct
- instr_count  output  CNT_W  retired instructions
- state  output  4  current state, for the bench

## Operation
- Reset: state = FETCH, instr_count = 0; while reset is high, all enables/strobes/pulses = 0, all selects = 0.
- FETCH: mem_read, i_or_d=0, ir_write, alu_src_a=0, alu_src_b=01, add, pc_source=00, pc_write -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). lw/sw -> MEM_ADDR; R-type -> R_EXEC; beq/bne -> BRANCH; j -> JUMP; addi/andi/ori/slti -> I_EXEC; jal -> JAL. Anything else: illegal_op, -> FETCH.
- R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; any other funct is illegal.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add -> MEM_READ (lw) / MEM_WRITE (sw).
- MEM_READ: mem_read, i_or_d=1 -> MEM_WB. MEM_WB: reg_write, reg_dst=00, mem_to_reg=01, instr_done -> FETCH.
- MEM_WRITE: mem_write, i_or_d=1, instr_done -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct -> R_WB. R_WB: reg_write, reg_dst=01, mem_to_reg=00, instr_done -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, add/and/or/slt, zero_ext for andi/ori -> I_WB. I_WB: reg_write, reg_dst=00, mem_to_reg=00, instr_done -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_source=01. pc_write = zero for beq, ~zero for bne; instr_done -> FETCH.
- JUMP: pc_source=10, pc_write, instr_done -> FETCH.
- instr_count increments on every clock with instr_done=1. It wraps at 2^CNT_W. Illegal instructions are not counted.

## Timing
- Moore outputs, except pc_write in BRANCH, which depends combinationally on zero.
- CPI: lw 5, sw 4, R 4, I-type 4, beq/bne 3, j 3, jal 3, illegal 2.
- Reset asserted mid-instruction: FSM returns to FETCH immediately and drops all writes. The first fetch happens on the first rising edge after release.
- instr_count updates on the same edge that leaves the final state.

## Configuration
- MC_JAL_EN defined: opcode 0x03 (jal) -> JAL state: reg_write, reg_dst=10, mem_to_reg=10, pc_source=10, pc_write, instr_done.
- MC_JAL_EN undefined: the JAL state is absent and opcode 0x03 is illegal. Port widths are unchanged.

## Structure
- Package mc_pkg holds the state enum (4-bit), opcode/funct constants, alu_ctrl codes, and the mux-select encodings shared with the datapath.
- Sub-module alu_control_decode: combinational mapping of (state class, opcode, funct) to alu_ctrl plus a funct-legal flag.

## Test plan
- Reset held 3 cycles, then released with opcode=0x23 (lw): states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. mem_to_reg=01 in the last state; instr_count=1.
- R-type funct=0x2A: alu_ctrl=0111 in R_EXEC; reg_dst=01 with reg_write in R_WB; 4 cycles total.
- beq with zero=1 -> pc_write=1 in BRANCH. bne with zero=1 -> pc_write=0. bne with zero=0 -> pc_write=1.
- opcode=0x3F, or R-type with funct=0x00: illegal_op pulses in DECODE, next state is FETCH, instr_count unchanged.
- Reset asserted during MEM_WRITE: mem_write drops asynchronously and state=FETCH without waiting for a clock edge.
- With MC_JAL_EN, jal: reg_dst=10, mem_to_reg=10, pc_write=1 in cycle 3. Without it: illegal_op.
